// File: rtl/mem_arbiter_pkg.sv
// Shared types and default tuning constants for the memory-port arbiter.
package mem_arbiter_pkg;

  // Which requester currently owns the memory port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2,
    GNT_L    = 2'd3
  } gnt_t;

  // Arbiter sequencing state: waiting to pick a winner, or one transaction in flight.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Consecutive D/L grants tolerated while fetch waits.
  localparam int STARVE_MAX_DEF = 3;

  // Cycles a transaction may stay outstanding before it is aborted.
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian byte-lane steering between the 16-bit memory word and byte accesses.
// Writes replicate the low byte onto both lanes and pick the byte enable from
// the address LSB; reads move the selected lane down and zero the upper byte.
module mem_byte_lane (
  input  logic        byt,
  input  logic        addr_lsb,
  input  logic        wr,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic [1:0]  be,
  output logic [15:0] wdata_lane,
  output logic [15:0] rdata_lane
);

  // Byte enables, replicated write data and aligned read data, all purely combinational.
  always_comb begin
    be         = 2'b11;
    wdata_lane = 16'h0000;
    rdata_lane = rdata;
    if (byt) begin
      be         = addr_lsb ? 2'b10 : 2'b01;
      rdata_lane = {8'h00, (addr_lsb ? rdata[15:8] : rdata[7:0])};
    end
    if (wr) begin
      wdata_lane = byt ? {wdata[7:0], wdata[7:0]} : wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single 16-bit memory port between instruction fetch (I), data
// access (D) and the program loader (L). Fixed priority D > L > I with a
// starvation guard that forces I through after STARVE_MAX back-to-back D/L
// grants; one transaction at a time, variable-latency ack, timeout abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_byt,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  input  logic        l_req,
  input  logic [15:0] l_addr,
  input  logic [15:0] l_wdata,
  output logic        l_ack,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  arb_state_t  state;
  gnt_t        gnt;
  gnt_t        win;
  logic [7:0]  starve_cnt;
  logic [15:0] tmo_cnt;
  logic        byt_q;
  logic        lsb_q;

  logic [15:0] win_addr;
  logic [15:0] win_wdata;
  logic        win_wr;
  logic        win_byt;

  logic        lane_byt;
  logic        lane_lsb;
  logic [1:0]  lane_be;
  logic [15:0] lane_wdata;
  logic [15:0] lane_rdata;

  logic        busy;
  logic        grant;
  logic        done;
  logic        tmo;
  logic        finish;

  assign busy   = (state == ARB_BUSY);
  assign grant  = !busy && (win != GNT_NONE);
  assign done   = busy && mem_ack;
  assign tmo    = busy && !mem_ack && (tmo_cnt == TMO_LAST);
  assign finish = done || tmo;

  assign mem_req = busy;
  assign bus_err = tmo;
  assign i_ack   = finish && (gnt == GNT_I);
  assign d_ack   = finish && (gnt == GNT_D);
  assign l_ack   = finish && (gnt == GNT_L);
  assign i_rdata = (done && (gnt == GNT_I)) ? mem_rdata  : 16'h0000;
  assign d_rdata = (done && (gnt == GNT_D)) ? lane_rdata : 16'h0000;

  // While idle the lane sees the prospective winner; while busy it sees the latched access.
  assign lane_byt = busy ? byt_q : win_byt;
  assign lane_lsb = busy ? lsb_q : win_addr[0];

  mem_byte_lane u_lane (
    .byt        (lane_byt),
    .addr_lsb   (lane_lsb),
    .wr         (win_wr),
    .wdata      (win_wdata),
    .rdata      (mem_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_lane (lane_rdata)
  );

  // Pick the winner: starved fetch first, otherwise D > L > I.
  always_comb begin
    win = GNT_NONE;
    if (i_req && (starve_cnt == STARVE_LIM)) begin
      win = GNT_I;
    end else if (d_req) begin
      win = GNT_D;
    end else if (l_req) begin
      win = GNT_L;
    end else if (i_req) begin
      win = GNT_I;
    end
  end

  // Gather the winner's request fields; fetch and loader are always word accesses.
  always_comb begin
    win_addr  = 16'h0000;
    win_wdata = 16'h0000;
    win_wr    = 1'b0;
    win_byt   = 1'b0;
    case (win)
      GNT_I: begin
        win_addr = i_addr;
      end
      GNT_D: begin
        win_addr  = d_addr;
        win_wdata = d_wdata;
        win_wr    = d_wr;
        win_byt   = d_byt;
      end
      GNT_L: begin
        win_addr  = l_addr;
        win_wdata = l_wdata;
        win_wr    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Transaction sequencer: latch the winner in IDLE, hold it stable until ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      gnt       <= GNT_NONE;
      mem_wr    <= 1'b0;
      mem_addr  <= 15'h0000;
      mem_be    <= 2'b00;
      mem_wdata <= 16'h0000;
      byt_q     <= 1'b0;
      lsb_q     <= 1'b0;
      tmo_cnt   <= 16'h0000;
    end else if (!busy) begin
      if (grant) begin
        state     <= ARB_BUSY;
        gnt       <= win;
        mem_wr    <= win_wr;
        mem_addr  <= win_addr[15:1];
        mem_be    <= lane_be;
        mem_wdata <= lane_wdata;
        byt_q     <= win_byt;
        lsb_q     <= win_addr[0];
        tmo_cnt   <= 16'h0000;
      end
    end else if (finish) begin
      state   <= ARB_IDLE;
      gnt     <= GNT_NONE;
      tmo_cnt <= 16'h0000;
    end else begin
      tmo_cnt <= tmo_cnt + 16'h0001;
    end
  end

  // Starvation guard: count D/L grants that bypass a waiting fetch, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'h00;
    end else if (!i_req) begin
      starve_cnt <= 8'h00;
    end else if (grant) begin
      if (win == GNT_I) begin
        starve_cnt <= 8'h00;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request mixes, checked against a priority/starvation model of the arbiter.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic        d_byt = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        l_req = 1'b0;
  logic [15:0] l_addr = 16'h0000;
  logic [15:0] l_wdata = 16'h0000;
  logic        l_ack;
  logic        bus_err;
  logic        mem_req;
  logic        mem_wr;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  int checks = 0;
  int errors = 0;
  int consec = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_byt     (d_byt),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .l_req     (l_req),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_ack     (l_ack),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Port codes: 1 = fetch, 2 = data, 3 = loader.
  task automatic applyStimulus(input int port, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic wr, input logic byt);
    case (port)
      1: begin i_req = 1'b1; i_addr = addr; end
      2: begin d_req = 1'b1; d_addr = addr; d_wdata = wdata; d_wr = wr; d_byt = byt; end
      3: begin l_req = 1'b1; l_addr = addr; l_wdata = wdata; end
      default: begin end
    endcase
  endtask

  task automatic dropReq(input int port);
    case (port)
      1: i_req = 1'b0;
      2: d_req = 1'b0;
      3: l_req = 1'b0;
      default: begin end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: a fetch bypassed STARVE_MAX times wins, else data, loader, fetch.
  function automatic int predictWinner();
    if (i_req && consec >= STARVE_MAX) return 1;
    if (d_req) return 2;
    if (l_req) return 3;
    if (i_req) return 1;
    return 0;
  endfunction

  function automatic void updateModel(input int w);
    if (w == 1 || !i_req) consec = 0;
    else consec = (consec + 1 > STARVE_MAX) ? STARVE_MAX : consec + 1;
  endfunction

  // Returns positioned at a falling edge with mem_req high, or after the bound expires.
  task automatic waitMemReq(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!mem_req && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // One complete transaction: predict, check request fields, ack after lat cycles, check completion.
  task automatic runTransaction(input string tag, input int lat, input logic [15:0] rdata,
                                output int w, output int gap);
    logic [14:0] ea;
    logic        ewr;
    logic [1:0]  ebe;
    logic [15:0] ewd;
    logic [15:0] erd;
    logic [2:0]  eack;
    w    = predictWinner();
    ea   = 15'h0000;
    ewr  = 1'b0;
    ebe  = 2'b11;
    ewd  = 16'h0000;
    erd  = rdata;
    eack = 3'b000;
    case (w)
      1: begin ea = i_addr[15:1]; eack = 3'b100; end
      2: begin
        ea   = d_addr[15:1];
        ewr  = d_wr;
        eack = 3'b010;
        if (d_byt) begin
          ebe = d_addr[0] ? 2'b10 : 2'b01;
          ewd = {d_wdata[7:0], d_wdata[7:0]};
          erd = {8'h00, (d_addr[0] ? rdata[15:8] : rdata[7:0])};
        end else begin
          ewd = d_wdata;
        end
      end
      3: begin ea = l_addr[15:1]; ewr = 1'b1; ewd = l_wdata; eack = 3'b001; end
      default: begin end
    endcase
    waitMemReq(gap);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(ea));
    checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'(ewr));
    checkOutput({tag, "_mem_be"}, 32'(mem_be), 32'(ebe));
    if (ewr) checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(ewd));
    if (lat > 1) begin
      checkOutput({tag, "_early_ack"}, 32'({i_ack, d_ack, l_ack, bus_err}), 32'd0);
      for (int k = 1; k < lat; k++) @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    checkOutput({tag, "_acks"}, 32'({i_ack, d_ack, l_ack}), 32'(eack));
    checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    if (w == 1) checkOutput({tag, "_i_rdata"}, 32'(i_rdata), 32'(erd));
    else checkOutput({tag, "_i_rdata_idle"}, 32'(i_rdata), 32'd0);
    if (w == 2 && !ewr) checkOutput({tag, "_d_rdata"}, 32'(d_rdata), 32'(erd));
    else if (w != 2) checkOutput({tag, "_d_rdata_idle"}, 32'(d_rdata), 32'd0);
    updateModel(w);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  initial begin
    int w;
    int gap;
    int early;

    // Reset state with memory driving garbage read data.
    mem_rdata = 16'hFFFF;
    #2;
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_fields", 32'({mem_wr, mem_addr, mem_be}), 32'd0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset_acks", 32'({i_ack, d_ack, l_ack, bus_err}), 32'd0);
    checkOutput("reset_rdata", {i_rdata, d_rdata}, 32'd0);
    mem_rdata = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Data word read, memory answers in the third busy cycle.
    applyStimulus(2, 16'h0100, 16'h0000, 1'b0, 1'b0);
    runTransaction("d_word_rd", 3, 16'hBEEF, w, gap);
    dropReq(w);

    // Byte write to the odd lane, then byte read of the odd lane.
    applyStimulus(2, 16'h0101, 16'h12AB, 1'b1, 1'b1);
    runTransaction("d_byte_wr", 2, 16'h0000, w, gap);
    dropReq(w);
    applyStimulus(2, 16'h0101, 16'h0000, 1'b0, 1'b1);
    runTransaction("d_byte_rd", 1, 16'h3456, w, gap);
    dropReq(w);

    // All three at once, zero-wait memory: D, L, I with one idle cycle between.
    applyStimulus(1, 16'h0400, 16'h0000, 1'b0, 1'b0);
    applyStimulus(2, 16'h0500, 16'hCAFE, 1'b1, 1'b0);
    applyStimulus(3, 16'h0600, 16'h1234, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      runTransaction("order", 1, 16'h0A0A + 16'(n), w, gap);
      checkOutput("order_gap", 32'(gap), 32'd1);
      dropReq(w);
    end

    // Fetch held against continuous data traffic: three D grants, then I, then D again.
    applyStimulus(1, 16'h0800, 16'h0000, 1'b0, 1'b0);
    applyStimulus(2, 16'h0900, 16'h0000, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      runTransaction("starve", 1, 16'h7000 + 16'(n), w, gap);
      if (w == 1) dropReq(1);
    end
    dropReq(2);
    tick();

    // Memory never answers: abort with bus_err in the TIMEOUT-th busy cycle.
    mem_rdata = 16'hDEAD;
    applyStimulus(2, 16'h0200, 16'h0000, 1'b0, 1'b0);
    waitMemReq(gap);
    checkOutput("tmo_mem_req", 32'(mem_req), 32'd1);
    early = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      if (d_ack || bus_err) early++;
      @(negedge clk);
    end
    #1;
    checkOutput("tmo_early_ack", 32'(early), 32'd0);
    checkOutput("tmo_d_ack", 32'(d_ack), 32'd1);
    checkOutput("tmo_bus_err", 32'(bus_err), 32'd1);
    checkOutput("tmo_d_rdata", 32'(d_rdata), 32'd0);
    updateModel(2);
    tick();
    dropReq(2);
    mem_rdata = 16'h0000;
    @(negedge clk);
    checkOutput("tmo_mem_req_drop", 32'(mem_req), 32'd0);
    tick();

    // Ack arriving in the last allowed cycle completes normally.
    applyStimulus(2, 16'h0202, 16'h0000, 1'b0, 1'b0);
    runTransaction("tmo_edge", TIMEOUT, 16'h600D, w, gap);
    dropReq(w);

    // Reset in the middle of a transaction, then the pending request goes out again.
    applyStimulus(2, 16'h0300, 16'h0000, 1'b0, 1'b0);
    waitMemReq(gap);
    checkOutput("rst_busy_mem_req", 32'(mem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_req_drop", 32'(mem_req), 32'd0);
    checkOutput("rst_no_ack", 32'({i_ack, d_ack, l_ack, bus_err}), 32'd0);
    consec = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    runTransaction("rst_reissue", 2, 16'h5A5A, w, gap);
    dropReq(w);

    // Random mixes of outstanding requests with random memory latency.
    for (int n = 0; n < 40; n++) begin
      if (!i_req && $urandom_range(1, 0) == 1)
        applyStimulus(1, 16'($urandom), 16'h0000, 1'b0, 1'b0);
      if (!d_req && $urandom_range(1, 0) == 1)
        applyStimulus(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if (!l_req && $urandom_range(1, 0) == 1)
        applyStimulus(3, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      if (!i_req && !d_req && !l_req)
        applyStimulus(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      runTransaction("rnd", $urandom_range(4, 1), 16'($urandom), w, gap);
      dropReq(w);
    end

    // Drain whatever the random phase left pending.
    while (i_req || d_req || l_req) begin
      runTransaction("drain", 1, 16'($urandom), w, gap);
      dropReq(w);
      if (w == 0) begin
        dropReq(1);
        dropReq(2);
        dropReq(3);
      end
    end
    @(negedge clk);
    checkOutput("final_idle", 32'(mem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
